// File: rtl/alu_issue_queue_pkg.sv
// Shared types and sizes for the ALU issue queue: renamed register tags,
// bypass bus layout, queue entry and the issue bus to execute.
package alu_issue_queue_pkg;

  localparam int ALU_IQ_DEPTH      = 8;
  localparam int ALU_IQ_NUM_BYPASS = 3;
  localparam int PHY_REG_W         = 6;

  typedef logic [PHY_REG_W-1:0] reg_addr_t;
  typedef logic [31:0]          uint32_t;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [15:0] imm;
  } decoded_inst_t;

  typedef struct packed {
    logic [3:0] we;
    reg_addr_t  phy_dest;
    uint32_t    value;
  } bypass_bus_t;

  typedef struct packed {
    decoded_inst_t inst;
    reg_addr_t     phy_dest;
    uint32_t       src1_value;
    uint32_t       src2_value;
  } issue_to_execute_bus_t;

  typedef struct packed {
    logic          valid;
    decoded_inst_t inst;
    reg_addr_t     phy_dest;
    reg_addr_t     src1;
    reg_addr_t     src2;
    logic          src1_rdy;
    logic          src2_rdy;
  } iq_entry_t;

  // p0 is hard-wired zero: it is never produced, so it never wakes or forwards.
  function automatic logic bus_hits(bypass_bus_t b, reg_addr_t src);
    return (b.we != 4'h0) && (b.phy_dest == src) && (src != '0);
  endfunction

endpackage

// File: rtl/iq_age_select.sv
// Oldest-first picker: grants the ready entry that has no older ready entry.
// age[i][j]=1 means entry i is younger than entry j.
module iq_age_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            i_ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
  output logic [DEPTH-1:0]            o_grant,
  output logic                        o_any_grant
);

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_ready[i] && ((i_ready & i_age[i]) == '0);
    end
  end

  assign o_any_grant = |i_ready;

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: holds renamed ops until both sources are ready, wakes them
// from the bypass buses and issues the oldest ready one with forwarded operands.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH      = ALU_IQ_DEPTH,
  parameter int NUM_BYPASS = ALU_IQ_NUM_BYPASS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  dispatch_valid,
  output logic                  iq_allowin,
  input  decoded_inst_t         dispatch_inst,
  input  reg_addr_t             dispatch_phy_dest,
  input  reg_addr_t             dispatch_src1,
  input  reg_addr_t             dispatch_src2,
  input  logic                  dispatch_src1_rdy,
  input  logic                  dispatch_src2_rdy,
  input  bypass_bus_t           bypass_bus [NUM_BYPASS],
  output reg_addr_t             rf_raddr1,
  output reg_addr_t             rf_raddr2,
  input  uint32_t               rf_rdata1,
  input  uint32_t               rf_rdata2,
  output logic                  issue_to_alu_valid,
  input  logic                  alu_allowin,
  output issue_to_execute_bus_t issue_inst
);

  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t                   r_q [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] r_age;

  logic [DEPTH-1:0] w_valid, w_ready, w_grant, w_wake1, w_wake2;
  logic             w_any_grant, w_disp_wake1, w_disp_wake2;
  logic             w_dispatch, w_issue;
  logic [IDX_W-1:0] w_alloc_idx, w_sel_idx;
  uint32_t          w_src1_value, w_src2_value;

  always_comb begin
    w_valid      = '0;
    w_ready      = '0;
    w_wake1      = '0;
    w_wake2      = '0;
    w_disp_wake1 = 1'b0;
    w_disp_wake2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_q[i].valid;
      w_ready[i] = r_q[i].valid && r_q[i].src1_rdy && r_q[i].src2_rdy;
      for (int b = 0; b < NUM_BYPASS; b++) begin
        if (bus_hits(bypass_bus[b], r_q[i].src1)) w_wake1[i] = 1'b1;
        if (bus_hits(bypass_bus[b], r_q[i].src2)) w_wake2[i] = 1'b1;
      end
    end
    for (int b = 0; b < NUM_BYPASS; b++) begin
      if (bus_hits(bypass_bus[b], dispatch_src1)) w_disp_wake1 = 1'b1;
      if (bus_hits(bypass_bus[b], dispatch_src2)) w_disp_wake2 = 1'b1;
    end
  end

  always_comb begin
    w_alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!w_valid[i]) w_alloc_idx = IDX_W'(i);
    end
  end

  iq_age_select #(.DEPTH(DEPTH)) u_age_select (
    .i_ready     (w_ready),
    .i_age       (r_age),
    .o_grant     (w_grant),
    .o_any_grant (w_any_grant)
  );

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) w_sel_idx = IDX_W'(i);
    end
  end

  // A slot freed by this cycle's issue is deliberately not offered to dispatch.
  assign iq_allowin         = !(&w_valid) && !flush;
  assign w_dispatch         = dispatch_valid && iq_allowin;
  assign issue_to_alu_valid = w_any_grant && !flush;
  assign w_issue            = issue_to_alu_valid && alu_allowin;

  assign rf_raddr1 = w_any_grant ? r_q[w_sel_idx].src1 : '0;
  assign rf_raddr2 = w_any_grant ? r_q[w_sel_idx].src2 : '0;

  // Lowest-index bypass bus wins; walk downwards so it is assigned last.
  always_comb begin
    w_src1_value = (rf_raddr1 == '0) ? '0 : rf_rdata1;
    w_src2_value = (rf_raddr2 == '0) ? '0 : rf_rdata2;
    for (int b = NUM_BYPASS - 1; b >= 0; b--) begin
      if (bus_hits(bypass_bus[b], rf_raddr1)) w_src1_value = bypass_bus[b].value;
      if (bus_hits(bypass_bus[b], rf_raddr2)) w_src2_value = bypass_bus[b].value;
    end
  end

  always_comb begin
    issue_inst = '0;
    if (w_any_grant) begin
      issue_inst.inst       = r_q[w_sel_idx].inst;
      issue_inst.phy_dest   = r_q[w_sel_idx].phy_dest;
      issue_inst.src1_value = w_src1_value;
      issue_inst.src2_value = w_src2_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_age <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q[i].valid && w_wake1[i]) r_q[i].src1_rdy <= 1'b1;
        if (r_q[i].valid && w_wake2[i]) r_q[i].src2_rdy <= 1'b1;
        if (w_issue && w_grant[i])      r_q[i].valid    <= 1'b0;
      end
      if (w_dispatch) begin
        r_q[w_alloc_idx] <= '{valid:    1'b1,
                              inst:     dispatch_inst,
                              phy_dest: dispatch_phy_dest,
                              src1:     dispatch_src1,
                              src2:     dispatch_src2,
                              src1_rdy: dispatch_src1_rdy || w_disp_wake1,
                              src2_rdy: dispatch_src2_rdy || w_disp_wake2};
        // Everything valid now is older than the new entry; nothing is younger.
        r_age[w_alloc_idx] <= w_valid;
        for (int j = 0; j < DEPTH; j++) r_age[j][w_alloc_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: hand-computed vectors plus a scoreboard
// of expected issue order checked at every issue handshake.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  flush = 1'b0;
  logic                  dispatch_valid = 1'b0;
  logic                  iq_allowin;
  decoded_inst_t         dispatch_inst = '0;
  reg_addr_t             dispatch_phy_dest = '0;
  reg_addr_t             dispatch_src1 = '0;
  reg_addr_t             dispatch_src2 = '0;
  logic                  dispatch_src1_rdy = 1'b0;
  logic                  dispatch_src2_rdy = 1'b0;
  bypass_bus_t           bypass_bus [ALU_IQ_NUM_BYPASS];
  reg_addr_t             rf_raddr1, rf_raddr2;
  uint32_t               rf_rdata1, rf_rdata2;
  logic                  issue_to_alu_valid;
  logic                  alu_allowin = 1'b1;
  issue_to_execute_bus_t issue_inst;

  int n_vec = 0;
  int n_err = 0;
  logic [PHY_REG_W-1:0] exp_q[$];

  alu_issue_queue dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .dispatch_valid     (dispatch_valid),
    .iq_allowin         (iq_allowin),
    .dispatch_inst      (dispatch_inst),
    .dispatch_phy_dest  (dispatch_phy_dest),
    .dispatch_src1      (dispatch_src1),
    .dispatch_src2      (dispatch_src2),
    .dispatch_src1_rdy  (dispatch_src1_rdy),
    .dispatch_src2_rdy  (dispatch_src2_rdy),
    .bypass_bus         (bypass_bus),
    .rf_raddr1          (rf_raddr1),
    .rf_raddr2          (rf_raddr2),
    .rf_rdata1          (rf_rdata1),
    .rf_rdata2          (rf_rdata2),
    .issue_to_alu_valid (issue_to_alu_valid),
    .alu_allowin        (alu_allowin),
    .issue_inst         (issue_inst)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Physical register file model: every register holds a recognisable value.
  function automatic uint32_t rf_val(input reg_addr_t a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction
  assign rf_rdata1 = rf_val(rf_raddr1);
  assign rf_rdata2 = rf_val(rf_raddr2);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic settle();
    #2;
  endtask

  task automatic cyc();
    if (issue_to_alu_valid && alu_allowin) begin
      if (exp_q.size() == 0) check("unexpected_issue", {122'b0, issue_inst.phy_dest}, 128'hFFFF);
      else                   check("issue_order", {122'b0, issue_inst.phy_dest}, {122'b0, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
    dispatch_valid = 1'b0;
    flush          = 1'b0;
    for (int b = 0; b < ALU_IQ_NUM_BYPASS; b++) bypass_bus[b] = '0;
  endtask

  task automatic disp(input reg_addr_t dest, input reg_addr_t s1, input logic r1,
                      input reg_addr_t s2, input logic r2, input logic [3:0] op);
    dispatch_valid    = 1'b1;
    dispatch_inst     = '{alu_op: op, imm: 16'h0};
    dispatch_phy_dest = dest;
    dispatch_src1     = s1;
    dispatch_src1_rdy = r1;
    dispatch_src2     = s2;
    dispatch_src2_rdy = r2;
  endtask

  task automatic bus(input int b, input reg_addr_t d, input uint32_t v);
    bypass_bus[b] = '{we: 4'hf, phy_dest: d, value: v};
  endtask

  task automatic chk_valid(input string tag, input logic exp);
    check(tag, {127'b0, issue_to_alu_valid}, {127'b0, exp});
  endtask

  task automatic chk_dest(input string tag, input reg_addr_t exp);
    check(tag, {122'b0, issue_inst.phy_dest}, {122'b0, exp});
  endtask

  initial begin
    for (int b = 0; b < ALU_IQ_NUM_BYPASS; b++) bypass_bus[b] = '0;

    // Reset values while reset is held
    #3;
    check("rst_allowin", {127'b0, iq_allowin}, 128'd1);
    chk_valid("rst_valid", 1'b0);
    check("rst_raddr1", {122'b0, rf_raddr1}, 128'd0);
    check("rst_inst", {38'b0, issue_inst}, 128'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("idle_allowin", {127'b0, iq_allowin}, 128'd1);
      chk_valid("idle_valid", 1'b0);
      cyc();
    end

    // ADDU p5 <- p1, p2 both ready: issues next cycle from the RF
    disp(6'd5, 6'd1, 1'b1, 6'd2, 1'b1, 4'h1);
    settle(); chk_valid("addu_lat0", 1'b0); cyc();
    settle();
    chk_valid("addu_valid", 1'b1);
    check("addu_raddr1", {122'b0, rf_raddr1}, 128'd1);
    check("addu_raddr2", {122'b0, rf_raddr2}, 128'd2);
    check("addu_s1v", {96'b0, issue_inst.src1_value}, {96'b0, rf_val(6'd1)});
    check("addu_s2v", {96'b0, issue_inst.src2_value}, {96'b0, rf_val(6'd2)});
    check("addu_op", {124'b0, issue_inst.inst.alu_op}, 128'h1);
    chk_dest("addu_dest", 6'd5);
    exp_q.push_back(6'd5); cyc();

    // Source p0 always reads zero even though the RF returns nonzero for it
    disp(6'd6, 6'd3, 1'b1, 6'd0, 1'b1, 4'h2);
    settle(); chk_valid("p0_lat0", 1'b0);
    check("empty_raddr1", {122'b0, rf_raddr1}, 128'd0); cyc();
    settle();
    chk_dest("p0_dest", 6'd6);
    check("p0_raddr2", {122'b0, rf_raddr2}, 128'd0);
    check("p0_s2v", {96'b0, issue_inst.src2_value}, 128'd0);
    check("p0_s1v", {96'b0, issue_inst.src1_value}, {96'b0, rf_val(6'd3)});
    exp_q.push_back(6'd6); cyc();

    // A waits on p7, B is ready: B first, A after the wakeup with forwarding
    disp(6'd10, 6'd7, 1'b0, 6'd3, 1'b1, 4'h3);
    settle(); chk_valid("ab_a_wait", 1'b0); cyc();
    disp(6'd11, 6'd4, 1'b1, 6'd5, 1'b1, 4'h4);
    settle(); chk_valid("ab_b_lat0", 1'b0); cyc();
    bus(1, 6'd7, 32'h1234);
    settle();
    chk_dest("ab_b_first", 6'd11);
    check("ab_b_s1v", {96'b0, issue_inst.src1_value}, {96'b0, rf_val(6'd4)});
    exp_q.push_back(6'd11); cyc();
    bypass_bus[0] = '{we: 4'h0, phy_dest: 6'd7, value: 32'hDEAD};
    bus(1, 6'd7, 32'h1234);
    bus(2, 6'd7, 32'h9999);
    settle();
    chk_valid("ab_a_valid", 1'b1);
    chk_dest("ab_a_dest", 6'd10);
    check("ab_a_raddr1", {122'b0, rf_raddr1}, 128'd7);
    check("ab_a_fwd", {96'b0, issue_inst.src1_value}, 128'h1234);
    check("ab_a_s2v", {96'b0, issue_inst.src2_value}, {96'b0, rf_val(6'd3)});
    exp_q.push_back(6'd10); cyc();
    settle(); chk_valid("ab_empty", 1'b0); cyc();

    // Fill all entries with unready sources; ninth dispatch is refused
    for (int i = 0; i < 8; i++) begin
      disp(reg_addr_t'(20 + i), reg_addr_t'(30 + i), 1'b0, 6'd1, 1'b1, 4'h5);
      settle(); check("fill_allowin", {127'b0, iq_allowin}, 128'd1); cyc();
    end
    disp(6'd40, 6'd1, 1'b1, 6'd2, 1'b1, 4'h6);
    settle();
    check("full_allowin", {127'b0, iq_allowin}, 128'd0);
    chk_valid("full_valid", 1'b0); cyc();
    bus(0, 6'd33, 32'h0);
    settle();
    check("full_wake_allowin", {127'b0, iq_allowin}, 128'd0);
    chk_valid("full_no_ninth", 1'b0); cyc();
    settle();
    chk_dest("full_issue_dest", 6'd23);
    check("full_issue_allowin", {127'b0, iq_allowin}, 128'd0);
    exp_q.push_back(6'd23); cyc();
    settle();
    check("full_freed_allowin", {127'b0, iq_allowin}, 128'd1);
    chk_valid("full_after_valid", 1'b0); cyc();
    flush = 1'b1;
    settle(); check("flush_allowin", {127'b0, iq_allowin}, 128'd0); cyc();
    settle(); check("post_flush_allowin", {127'b0, iq_allowin}, 128'd1); cyc();

    // Stall with two ready entries, then check age order survives slot reuse
    alu_allowin = 1'b0;
    disp(6'd50, 6'd1, 1'b1, 6'd2, 1'b1, 4'h7);
    settle(); chk_valid("stall_lat0", 1'b0); cyc();
    disp(6'd51, 6'd3, 1'b1, 6'd4, 1'b1, 4'h8);
    settle(); chk_dest("stall_c1", 6'd50); cyc();
    settle(); chk_dest("stall_c2", 6'd50);
    check("stall_raddr1", {122'b0, rf_raddr1}, 128'd1); cyc();
    settle(); chk_dest("stall_c3", 6'd50); cyc();
    alu_allowin = 1'b1;
    settle(); chk_dest("stall_release", 6'd50); exp_q.push_back(6'd50); cyc();
    alu_allowin = 1'b0;
    disp(6'd52, 6'd5, 1'b1, 6'd6, 1'b1, 4'h9);
    settle(); chk_dest("age_d_sel", 6'd51); cyc();
    alu_allowin = 1'b1;
    settle(); chk_dest("age_d_first", 6'd51);
    check("age_d_raddr1", {122'b0, rf_raddr1}, 128'd3);
    exp_q.push_back(6'd51); cyc();
    settle(); chk_dest("age_g_next", 6'd52); exp_q.push_back(6'd52); cyc();
    settle(); chk_valid("age_empty", 1'b0); cyc();

    // p0 wakeup ignored; flush with dispatch and wakeup in the same cycle
    alu_allowin = 1'b0;
    disp(6'd80, 6'd1, 1'b1, 6'd2, 1'b1, 4'h1);
    settle(); chk_valid("fl_lat0", 1'b0); cyc();
    disp(6'd81, 6'd0, 1'b0, 6'd1, 1'b1, 4'h1);
    settle(); chk_dest("fl_p_sel", 6'd80); cyc();
    disp(6'd82, 6'd40, 1'b0, 6'd1, 1'b1, 4'h1);
    bus(0, 6'd0, 32'h5);
    cyc();
    disp(6'd83, 6'd1, 1'b1, 6'd2, 1'b1, 4'h1);
    alu_allowin = 1'b1;
    settle(); chk_dest("fl_p_issue", 6'd80); exp_q.push_back(6'd80); cyc();
    alu_allowin = 1'b0;
    disp(6'd85, 6'd42, 1'b0, 6'd1, 1'b1, 4'h1);
    settle(); chk_dest("fl_no_p0_wake", 6'd83); cyc();
    alu_allowin = 1'b1;
    flush = 1'b1;
    disp(6'd84, 6'd1, 1'b1, 6'd2, 1'b1, 4'h1);
    bus(0, 6'd40, 32'h7);
    settle();
    chk_valid("fl_cycle_valid", 1'b0);
    check("fl_cycle_allowin", {127'b0, iq_allowin}, 128'd0); cyc();
    settle();
    chk_valid("fl_after_valid", 1'b0);
    check("fl_after_allowin", {127'b0, iq_allowin}, 128'd1); cyc();

    // Asynchronous reset in the middle of a cycle
    alu_allowin = 1'b0;
    disp(6'd86, 6'd1, 1'b1, 6'd2, 1'b1, 4'h1);
    cyc();
    settle(); chk_dest("ar_before", 6'd86);
    #1 reset = 1'b0;
    #1;
    chk_valid("ar_valid", 1'b0);
    check("ar_allowin", {127'b0, iq_allowin}, 128'd1);
    check("ar_raddr1", {122'b0, rf_raddr1}, 128'd0);
    check("ar_inst", {38'b0, issue_inst}, 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    alu_allowin = 1'b1;
    settle(); chk_valid("ar_after_valid", 1'b0); cyc();

    check("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
